// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and an elaboration-time parameter width guard.

`ifndef SSAM_WIDTH_CHECK
`define SSAM_WIDTH_CHECK(lbl, val, minval) \
  if ((val) < (minval)) begin : lbl \
    $error("seq_shift_add_mult: parameter below minimum width"); \
  end
`endif

package seq_shift_add_mult_pkg;

  // Two-bit FSM encoding: IDLE waits for start, RUN iterates, DONE pulses done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_abs.sv
// Magnitude extractor: returns |val| when sgn is set, the raw value otherwise,
// plus the operand's effective sign. The most negative value maps to its
// unsigned magnitude (e.g. 3'b100 -> 4), which still fits in N bits.

module seq_mult_abs #(
  parameter int N = 4
) (
  input  logic [N-1:0] val,
  input  logic         sgn,
  output logic [N-1:0] mag,
  output logic         neg
);

  localparam logic [N-1:0] ONE = 1;

  assign neg = sgn & val[N-1];
  assign mag = neg ? ((~val) + ONE) : val;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier. Operands are reduced to magnitudes at
// start, multiplied unsigned over A_WIDTH iterations (one multiplier bit per
// clock), and the sign is reapplied on the final iteration.
//
// Handshake: start is sampled only in IDLE or DONE; the cycle after it is
// accepted busy rises and stays high for exactly A_WIDTH cycles, then done
// pulses for one cycle with product valid. product is held until the next
// operation completes; start during RUN is ignored.

module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int A_WIDTH = 3,
  parameter int B_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sgn,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(A_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(A_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [PW-1:0] PROD_ONE = 1;

  generate
    `SSAM_WIDTH_CHECK(g_chk_a_width, A_WIDTH, 2)
    `SSAM_WIDTH_CHECK(g_chk_b_width, B_WIDTH, 2)
  endgenerate

  state_t              state;
  logic [A_WIDTH-1:0]  ma;
  logic [B_WIDTH-1:0]  mb;
  logic                neg;
  logic [PW-1:0]       acc;
  logic [CW-1:0]       cnt;

  logic [A_WIDTH-1:0]  a_mag;
  logic                a_neg;
  logic [B_WIDTH-1:0]  b_mag;
  logic                b_neg;
  logic [PW-1:0]       addend;
  logic [PW-1:0]       acc_next;

  seq_mult_abs #(.N(A_WIDTH)) u_abs_a (
    .val (a),
    .sgn (sgn),
    .mag (a_mag),
    .neg (a_neg)
  );

  seq_mult_abs #(.N(B_WIDTH)) u_abs_b (
    .val (b),
    .sgn (sgn),
    .mag (b_mag),
    .neg (b_neg)
  );

  // Partial product for the current multiplier bit, and the accumulator after adding it.
  always_comb begin
    addend   = {{A_WIDTH{1'b0}}, mb} << cnt;
    acc_next = acc;
    if (ma[cnt]) begin
      acc_next = acc + addend;
    end
  end

  // Control FSM with datapath registers; busy/done/product are registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      cnt     <= '0;
      ma      <= '0;
      mb      <= '0;
      neg     <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          cnt <= cnt + CNT_ONE;
          acc <= acc_next;
          if (cnt == CNT_LAST) begin
            product <= neg ? ((~acc_next) + PROD_ONE) : acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
          done <= 1'b0;
          if (start) begin
            ma    <= a_mag;
            mb    <= b_mag;
            neg   <= a_neg ^ b_neg;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: a default 3x4 instance for the directed
// scenarios plus an 8x8 instance for a randomized signed/unsigned sweep.
// Expected products come from plain integer arithmetic on the operands.

module tb_seq_shift_add_mult;

  localparam int AW0 = 3;
  localparam int BW0 = 4;
  localparam int AW1 = 8;
  localparam int BW1 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 start0 = 1'b0, sgn0 = 1'b0;
  logic [AW0-1:0]       a0 = '0;
  logic [BW0-1:0]       b0 = '0;
  logic                 busy0, done0;
  logic [AW0+BW0-1:0]   product0;

  logic                 start1 = 1'b0, sgn1 = 1'b0;
  logic [AW1-1:0]       a1 = '0;
  logic [BW1-1:0]       b1 = '0;
  logic                 busy1, done1;
  logic [AW1+BW1-1:0]   product1;

  seq_shift_add_mult #(.A_WIDTH(AW0), .B_WIDTH(BW0)) dut0 (
    .clk (clk), .rst (rst), .start (start0), .sgn (sgn0),
    .a (a0), .b (b0), .busy (busy0), .done (done0), .product (product0)
  );

  seq_shift_add_mult #(.A_WIDTH(AW1), .B_WIDTH(BW1)) dut1 (
    .clk (clk), .rst (rst), .start (start1), .sgn (sgn1),
    .a (a1), .b (b1), .busy (busy1), .done (done1), .product (product1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, keep aw+bw bits.
  function automatic logic [63:0] ref_prod(input logic s, input longint av, input longint bv,
                                           input int aw, input int bw);
    longint sa, sb, p;
    sa = av;
    sb = bv;
    if (s && av >= (longint'(1) << (aw - 1))) sa = av - (longint'(1) << aw);
    if (s && bv >= (longint'(1) << (bw - 1))) sb = bv - (longint'(1) << bw);
    p = sa * sb;
    return 64'(p & ((longint'(1) << (aw + bw)) - 1));
  endfunction

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic launch0(input logic s, input logic [AW0-1:0] av, input logic [BW0-1:0] bv);
    sgn0 = s; a0 = av; b0 = bv; start0 = 1'b1;
    exp_q.push_back(ref_prod(s, longint'(av), longint'(bv), AW0, BW0));
    @(posedge clk); #1;
    start0 = 1'b0;
    // Scramble inputs during RUN; they must not matter.
    a0 = AW0'($urandom); b0 = BW0'($urandom); sgn0 = 1'($urandom);
  endtask

  task automatic wait_done0(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done0 && lat < 40) begin
      if (busy0) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic launch1(input logic s, input logic [AW1-1:0] av, input logic [BW1-1:0] bv);
    sgn1 = s; a1 = av; b1 = bv; start1 = 1'b1;
    exp_q.push_back(ref_prod(s, longint'(av), longint'(bv), AW1, BW1));
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = AW1'($urandom); b1 = BW1'($urandom); sgn1 = 1'($urandom);
  endtask

  task automatic wait_done1(output int lat);
    lat = 0;
    while (!done1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full operation on dut0 with latency, busy width, result and pulse-width checks.
  task automatic op0(input string tag, input logic s, input logic [AW0-1:0] av,
                     input logic [BW0-1:0] bv);
    int lat, bcnt;
    logic [63:0] e;
    launch0(s, av, bv);
    wait_done0(lat, bcnt);
    e = exp_q.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(AW0));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(AW0));
    check({tag, "_busy_at_done"}, 64'(busy0), 64'd0);
    check({tag, "_product"}, 64'(product0), e);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done0), 64'd0);
    check({tag, "_product_hold"}, 64'(product0), e);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, bcnt, ndone;
    logic [63:0] e;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_done0", 64'(done0), 64'd0);
    check("rst_product0", 64'(product0), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_product1", 64'(product1), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the plan.
    op0("unsigned_7x15", 1'b0, 3'd7, 4'd15);
    op0("signed_m3x6", 1'b1, 3'b101, 4'b0110);
    op0("signed_m4xm8", 1'b1, 3'b100, 4'b1000);

    // Zero operand followed by a back-to-back start in the DONE cycle.
    launch0(1'b0, 3'd0, 4'd9);
    wait_done0(lat, bcnt);
    e = exp_q.pop_front();
    check("zero_lat", 64'(lat), 64'(AW0));
    check("zero_product", 64'(product0), e);
    launch0(1'b0, 3'd5, 4'd3);
    check("b2b_hold_first", 64'(product0), e);
    check("b2b_busy", 64'(busy0), 64'd1);
    wait_done0(lat, bcnt);
    e = exp_q.pop_front();
    check("b2b_lat", 64'(lat), 64'(AW0));
    check("b2b_product", 64'(product0), e);
    @(posedge clk); #1;

    // start pulsed mid-RUN must be ignored.
    launch0(1'b0, 3'd3, 4'd4);
    @(posedge clk); #1;
    start0 = 1'b1; a0 = 3'd7; b0 = 4'd15;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done0(lat, bcnt);
    e = exp_q.pop_front();
    check("ignore_lat", 64'(lat), 64'(AW0 - 2));
    check("ignore_product", 64'(product0), e);
    ndone = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done0) ndone++;
    end
    check("ignore_single_done", 64'(ndone), 64'd0);
    check("ignore_idle_busy", 64'(busy0), 64'd0);

    // Reset asserted on the second RUN edge.
    launch0(1'b0, 3'd6, 4'd7);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_run_busy", 64'(busy0), 64'd0);
    check("rst_run_done", 64'(done0), 64'd0);
    check("rst_run_product", 64'(product0), 64'd0);
    check("rst_run_state", 64'(dut0.state), 64'd0);
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done0 || busy0) ndone++;
    end
    check("rst_run_no_done", 64'(ndone), 64'd0);

    // Random 3x4 operations.
    for (int i = 0; i < 12; i++) begin
      op0("rand3x4", 1'($urandom), AW0'($urandom), BW0'($urandom));
    end

    // 8x8 sweep, including extreme values.
    for (int i = 0; i < 24; i++) begin
      logic s;
      logic [AW1-1:0] av;
      logic [BW1-1:0] bv;
      s  = 1'($urandom);
      av = (i == 0) ? 8'h80 : (i == 1) ? 8'hff : AW1'($urandom_range(0, 255));
      bv = (i == 0) ? 8'h80 : (i == 1) ? 8'h80 : BW1'($urandom_range(0, 255));
      if (i < 2) s = 1'b1;
      launch1(s, av, bv);
      wait_done1(lat);
      e = exp_q.pop_front();
      check("sweep8_lat", 64'(lat), 64'(AW1));
      check("sweep8_product", 64'(product1), e);
      check("sweep8_busy_at_done", 64'(busy1), 64'd0);
      @(posedge clk); #1;
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
